// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the 320x480 @ ~57 Hz raster generator
// running one pixel per 12 MHz clock (half-rate horizontal 640x480 timing).
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_VIS  = 320;
    localparam int VGA_H_FP   = 8;
    localparam int VGA_H_SYNC = 48;
    localparam int VGA_H_BP   = 24;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync pulses are active-low in the standard 640x480 mode.
    localparam logic VGA_SYNC_POL = 1'b0;

    function automatic logic in_window(
        input logic [COORD_W-1:0] val,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (val >= lo) && (val <= hi);
    endfunction

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo-N counter with enable and synchronous reset; wrap_o flags the
// enabled terminal-count cycle so counters can be cascaded.
module mod_counter #(
    parameter int W       = 10,
    parameter int MODULUS = 400
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = at_last & en_i;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: cascaded h/v counters, registered decode of sync,
// visible-area flag, coordinates, strobes and a frame counter, all aligned.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS    = VGA_H_VIS,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_VIS    = VGA_V_VIS,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic               clk_12,
    input  logic               rst,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the coordinate range");
    end

    localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    mod_counter #(
        .W       (COORD_W),
        .MODULUS (H_TOTAL)
    ) u_h_cnt (
        .clk_i  (clk_12),
        .rst_i  (rst),
        .en_i   (pix_en),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    // The line-end wrap is the only thing that advances the line counter.
    mod_counter #(
        .W       (COORD_W),
        .MODULUS (V_TOTAL)
    ) u_v_cnt (
        .clk_i  (clk_12),
        .rst_i  (rst),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    // Frames completed so far; it sits alongside the counters so the
    // registered copy below lines up with the (0,0) output cycle.
    logic [7:0] frame_acc_q;
    logic [7:0] frame_acc_d;

    always_comb begin
        frame_acc_d = frame_acc_q;
        if (v_wrap) begin
            frame_acc_d = frame_acc_q + 8'd1;
        end
    end

    always_ff @(posedge clk_12) begin
        if (rst) begin
            frame_acc_q <= '0;
        end else begin
            frame_acc_q <= frame_acc_d;
        end
    end

    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               video_on_q,    video_on_d;
    logic [COORD_W-1:0] pix_x_q,       pix_x_d;
    logic [COORD_W-1:0] pix_y_q,       pix_y_d;
    logic               line_start_q,  line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [7:0]         frame_cnt_q,   frame_cnt_d;

    always_comb begin
        hsync_d       = sync_level(in_window(h_cnt, HS_START, HS_END), SYNC_POL);
        vsync_d       = sync_level(in_window(v_cnt, VS_START, VS_END), SYNC_POL);
        video_on_d    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        pix_x_d       = h_cnt;
        pix_y_d       = v_cnt;
        line_start_d  = (h_cnt == '0);
        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        frame_cnt_d   = frame_acc_q;
    end

    // Output stage: one enabled cycle behind the counters, everything in step.
    always_ff @(posedge clk_12) begin
        if (rst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (pix_en) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-width line timing on a short-frame instance, plus a
// tiny-raster instance used to walk frame_cnt through its 255->0 wrap.
module tb_vga_sync_gen;

    logic clk_12 = 1'b0;
    always #5 clk_12 = ~clk_12;

    logic rst;
    logic pix_en;

    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] pix_x, pix_y;
    logic [7:0] frame_cnt;

    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_pix_x, s_pix_y;
    logic [7:0] s_frame_cnt;

    // Default horizontal timing, 12-line frame (vsync on lines 8..9).
    vga_sync_gen #(
        .V_VIS (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
    ) dut (
        .clk_12      (clk_12),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // 8x6 raster: 48 clocks per frame.
    vga_sync_gen #(
        .H_VIS (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_VIS (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_s (
        .clk_12      (clk_12),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .pix_x       (s_pix_x),
        .pix_y       (s_pix_y),
        .line_start  (s_line_start),
        .frame_start (s_frame_start),
        .frame_cnt   (s_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_12);
        #1;
    endtask

    int hs_low, hs_first, von, ls_n;
    int vs_low, vs_first_x, vs_first_y, von_bad, fs_n, fs_prev, fs_bad;
    int falls, last_fall, bad, maxx, maxy, held_bad;
    logic prev_hs, found;
    logic [32:0] snap;

    initial begin
        rst    = 1'b1;
        pix_en = 1'b1;
        repeat (3) step();

        // Reset state
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video_on", video_on, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_s_frame_cnt", s_frame_cnt, 0);

        // First enabled edge shows (0,0)
        rst = 1'b0;
        step();
        chk("first_pix_x", pix_x, 0);
        chk("first_pix_y", pix_y, 0);
        chk("first_video_on", video_on, 1);
        chk("first_line_start", line_start, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_frame_cnt", frame_cnt, 0);
        chk("first_hsync", hsync, 1);

        // One full line
        hs_low = 0; hs_first = -1; von = 0; ls_n = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = pix_x;
            end
            if (video_on) von++;
            if (line_start) ls_n++;
            step();
        end
        chk("line_hsync_low", hs_low, 48);
        chk("line_hsync_first_x", hs_first, 328);
        chk("line_video_on", von, 320);
        chk("line_start_count", ls_n, 1);
        chk("line_wrap_x", pix_x, 0);
        chk("line_wrap_y", pix_y, 1);
        chk("line_wrap_ls", line_start, 1);
        chk("line_wrap_fs", frame_start, 0);

        // Two frames of 4800 clocks, starting from (0,1)
        vs_low = 0; vs_first_x = -1; vs_first_y = -1; von = 0; von_bad = 0;
        fs_n = 0; fs_prev = -1; fs_bad = 0; falls = 0; last_fall = -1; bad = 0;
        maxx = 0; maxy = 0; prev_hs = hsync;
        for (int i = 0; i < 9600; i++) begin
            if (!vsync) begin
                vs_low++;
                if (vs_first_y < 0) begin
                    vs_first_x = pix_x;
                    vs_first_y = pix_y;
                end
            end
            if (video_on) begin
                von++;
                if (pix_y >= 6) von_bad++;
            end
            if (frame_start) begin
                fs_n++;
                if (fs_prev >= 0 && (i - fs_prev) != 4800) fs_bad++;
                if (frame_cnt != 8'(fs_n)) fs_bad++;
                if (pix_x != 0 || pix_y != 0) fs_bad++;
                fs_prev = i;
            end
            if (prev_hs && !hsync) begin
                if (last_fall >= 0 && (i - last_fall) != 400) bad++;
                last_fall = i;
                falls++;
            end
            prev_hs = hsync;
            if (int'(pix_x) > maxx) maxx = pix_x;
            if (int'(pix_y) > maxy) maxy = pix_y;
            step();
        end
        chk("frame_vsync_low", vs_low, 1600);
        chk("frame_vsync_first_x", vs_first_x, 0);
        chk("frame_vsync_first_y", vs_first_y, 8);
        chk("frame_video_on", von, 3840);
        chk("frame_video_beyond_vis", von_bad, 0);
        chk("frame_start_count", fs_n, 2);
        chk("frame_start_bad", fs_bad, 0);
        chk("hsync_fall_count", falls, 24);
        chk("hsync_fall_period_bad", bad, 0);
        chk("max_pix_x", maxx, 399);
        chk("max_pix_y", maxy, 11);
        chk("frame_cnt_after", frame_cnt, 2);

        // Enable toggled every cycle
        falls = 0; last_fall = -1; bad = 0; held_bad = 0; prev_hs = hsync;
        for (int i = 0; i < 2000; i++) begin
            pix_en = i[0];
            snap = {hsync, vsync, video_on, pix_x, pix_y, line_start, frame_start, frame_cnt};
            step();
            if (!pix_en && ({hsync, vsync, video_on, pix_x, pix_y, line_start,
                             frame_start, frame_cnt} !== snap)) held_bad++;
            if (prev_hs && !hsync) begin
                if (last_fall >= 0 && (i - last_fall) != 800) bad++;
                last_fall = i;
                falls++;
            end
            prev_hs = hsync;
        end
        pix_en = 1'b1;
        chk("gated_hold_bad", held_bad, 0);
        chk("gated_fall_count", falls, 2);
        chk("gated_fall_period_bad", bad, 0);
        chk("gated_pos_x", pix_x, 200);
        chk("gated_pos_y", pix_y, 3);

        // Mid-frame reset at (200,4)
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (pix_x == 10'd200 && pix_y == 10'd4) found = 1'b1;
            else step();
        end
        chk("wait_200_4", found, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_vsync", vsync, 1);
        chk("mid_rst_video_on", video_on, 0);
        chk("mid_rst_pix_x", pix_x, 0);
        chk("mid_rst_pix_y", pix_y, 0);
        chk("mid_rst_frame_start", frame_start, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        step();
        chk("restart_pix_x", pix_x, 0);
        chk("restart_pix_y", pix_y, 0);
        chk("restart_frame_start", frame_start, 1);
        chk("restart_line_start", line_start, 1);
        chk("restart_video_on", video_on, 1);
        step();
        chk("restart_next_x", pix_x, 1);
        chk("restart_next_fs", frame_start, 0);
        chk("restart_next_ls", line_start, 0);

        // Tiny raster: walk to frame 255, then wrap
        maxx = 0; maxy = 0;
        for (int i = 0; i < 255 * 48 - 1; i++) begin
            step();
            if (int'(s_pix_x) > maxx) maxx = s_pix_x;
            if (int'(s_pix_y) > maxy) maxy = s_pix_y;
        end
        chk("s_max_pix_x", maxx, 7);
        chk("s_max_pix_y", maxy, 5);
        chk("s_f255_cnt", s_frame_cnt, 255);
        chk("s_f255_fs", s_frame_start, 1);
        repeat (47) step();
        chk("s_end_x", s_pix_x, 7);
        chk("s_end_y", s_pix_y, 5);
        chk("s_end_cnt", s_frame_cnt, 255);
        chk("s_end_fs", s_frame_start, 0);
        step();
        chk("s_wrap_cnt", s_frame_cnt, 0);
        chk("s_wrap_fs", s_frame_start, 1);
        chk("s_wrap_x", s_pix_x, 0);
        chk("s_wrap_y", s_pix_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
